// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Purpose  : PS/2 keyboard receiver for the emulated HPS keyboard stream.
//            Synchronises ps2_clk/ps2_data into clk_sys and deframes 11-bit
//            frames (start, 8 data LSB first, odd parity, stop). It folds
//            E0/F0 prefixes into single key events and queues the events in
//            a FIFO with a valid/ready handshake.
// Ports    : clk_sys   - system clock
//            reset     - synchronous active-high reset
//            ps2_clk   - PS/2 clock (idles high)
//            ps2_data  - PS/2 data
//            ev_valid  - event present at FIFO head
//            ev_ready  - consumer takes head event when ev_valid & ev_ready
//            ev_code   - set-2 base scan code
//            ev_ext    - event was E0-prefixed
//            ev_press  - 1 = make, 0 = break
//            overflow  - sticky, an event was dropped on a full FIFO
//            err_pulse - one-cycle pulse on parity/framing/timeout error
// Options  : PS2_KBD_RX_PAUSE_EN - when defined, E1 starts an 8-byte Pause
//            sequence that collapses into one {0x77, ext, press} event.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int FIFO_BITS = 3,
    parameter int TIMEOUT   = 16383
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_press,
    output logic       overflow,
    output logic       err_pulse
);

    localparam int c_DEPTH = 1 << FIFO_BITS;
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] r_clk_s;
    logic [1:0] r_dat_s;
    logic       r_clk_prev;
    logic       w_fe;
    logic       w_bit;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_s    <= 2'b11;
            r_dat_s    <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_s    <= {r_clk_s[0], ps2_clk};
            r_dat_s    <= {r_dat_s[0], ps2_data};
            r_clk_prev <= r_clk_s[1];
        end
    end

    assign w_fe  = r_clk_prev & ~r_clk_s[1];
    assign w_bit = r_dat_s[1];

    // ------------------------------------------------------------------
    // Deframer
    // ------------------------------------------------------------------
    logic [1:0]        r_state, w_state_nxt;
    logic [2:0]        r_idx, w_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_par, w_par_nxt;
    logic [c_TO_W-1:0] r_to_cnt, w_to_nxt;
    logic              w_timeout;
    logic              w_byte_done;
    logic              w_frame_err;
    logic              w_err;
    logic [7:0]        w_byte;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= 3'd0;
            r_shift  <= 8'd0;
            r_par    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    // A falling edge in the same cycle as the limit wins: the frame is
    // still alive.
    assign w_timeout = (r_state != c_ST_IDLE) && !w_fe &&
                       (r_to_cnt == c_TO_W'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;

        if (w_fe || (r_state == c_ST_IDLE) || w_timeout) begin
            w_to_nxt = '0;
        end else begin
            w_to_nxt = r_to_cnt + {{(c_TO_W-1){1'b0}}, 1'b1};
        end

        case (r_state)
            c_ST_IDLE: begin
                if (w_fe && !w_bit) begin
                    w_state_nxt = c_ST_DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            c_ST_DATA: begin
                if (w_fe) begin
                    // Shift in from the top so that after eight bits the
                    // first (LSB) bit sits at bit 0.
                    w_shift_nxt = {w_bit, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = c_ST_PARITY;
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_fe) begin
                    w_par_nxt   = w_bit;
                    w_state_nxt = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_fe) begin
                    if (w_bit && ((^r_shift) ^ r_par)) begin
                        w_byte_done = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    assign w_err  = w_frame_err | w_timeout;
    assign w_byte = r_shift;

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    logic       r_ext, w_ext_nxt;
    logic       r_rel, w_rel_nxt;
    logic       w_ev_push;
    logic [9:0] w_ev_data;
    logic       r_push;
    logic [9:0] r_push_data;
    logic       r_err_pulse;
`ifdef PS2_KBD_RX_PAUSE_EN
    logic [2:0] r_skip, w_skip_nxt;
`endif

    always_comb begin
        w_ext_nxt = r_ext;
        w_rel_nxt = r_rel;
        w_ev_push = 1'b0;
        w_ev_data = {w_byte, r_ext, ~r_rel};
`ifdef PS2_KBD_RX_PAUSE_EN
        w_skip_nxt = r_skip;
`endif
        if (w_err) begin
            w_ext_nxt = 1'b0;
            w_rel_nxt = 1'b0;
`ifdef PS2_KBD_RX_PAUSE_EN
            w_skip_nxt = 3'd0;
`endif
        end else if (w_byte_done) begin
`ifdef PS2_KBD_RX_PAUSE_EN
            // The seven bytes after E1 are swallowed; the last one
            // releases the single Pause event.
            if (r_skip != 3'd0) begin
                w_skip_nxt = r_skip - 3'd1;
                if (r_skip == 3'd1) begin
                    w_ev_push = 1'b1;
                    w_ev_data = {8'h77, 1'b1, 1'b1};
                end
            end else if (w_byte == 8'hE1) begin
                w_skip_nxt = 3'd7;
            end else
`endif
            begin
                case (w_byte)
                    8'hE0: w_ext_nxt = 1'b1;
                    8'hF0: w_rel_nxt = 1'b1;
                    8'hE1: begin
                        // Dropped; existing flags are left as they are.
                    end
                    default: begin
                        w_ev_push = 1'b1;
                        w_ext_nxt = 1'b0;
                        w_rel_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 10'd0;
            r_err_pulse <= 1'b0;
`ifdef PS2_KBD_RX_PAUSE_EN
            r_skip      <= 3'd0;
`endif
        end else begin
            r_ext       <= w_ext_nxt;
            r_rel       <= w_rel_nxt;
            r_push      <= w_ev_push;
            r_push_data <= w_ev_data;
            r_err_pulse <= w_err;
`ifdef PS2_KBD_RX_PAUSE_EN
            r_skip      <= w_skip_nxt;
`endif
        end
    end

    assign err_pulse = r_err_pulse;

    // ------------------------------------------------------------------
    // Event FIFO; pointer MSB separates full from empty
    // ------------------------------------------------------------------
    logic [9:0]         r_mem [c_DEPTH];
    logic [FIFO_BITS:0] r_wr;
    logic [FIFO_BITS:0] r_rd;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic [9:0]         w_head;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[FIFO_BITS] != r_rd[FIFO_BITS]) &&
                     (r_wr[FIFO_BITS-1:0] == r_rd[FIFO_BITS-1:0]);
    assign w_pop   = ~w_empty & ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en = r_push & (~w_full | w_pop);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 10'd0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr[FIFO_BITS-1:0]] <= r_push_data;
                r_wr <= r_wr + {{FIFO_BITS{1'b0}}, 1'b1};
            end
            if (r_push && !w_wr_en) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + {{FIFO_BITS{1'b0}}, 1'b1};
            end
        end
    end

    assign w_head   = r_mem[r_rd[FIFO_BITS-1:0]];
    assign ev_valid = ~w_empty;
    assign ev_code  = w_head[9:2];
    assign ev_ext   = w_head[1];
    assign ev_press = w_head[0];
    assign overflow = r_overflow;

endmodule
`default_nettype wire
